can_rx_destuff: RTL and testbench



---
 rtl/can_pkg.sv | 15 +
 rtl/can_crc15.sv | 26 ++
 rtl/can_rx_destuff.sv | 138 +++++++++++++
 tb/tb_can_rx_destuff.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: bit-stuffing length, CRC-15 polynomial/width and
// the receive destuffer state encoding.
package can_pkg;

   localparam int                 CAN_STUFF_LEN  = 5;
   localparam int                 CAN_CRC_W      = 15;
   localparam logic [CAN_CRC_W-1:0] CAN_CRC15_POLY = 15'h4599;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } destuff_state_e;

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 LFSR, MSB first, init 0. Shared by the receive
// destuffer and the transmit path.
module can_crc15
   import can_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 din,
   output logic [CAN_CRC_W-1:0] crc
);

   logic fb;

   assign fb = crc[CAN_CRC_W-1] ^ din;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : '0);
      end
   end

endmodule

// File: rtl/can_rx_destuff.sv
// CAN receive bit destuffer: drops stuff bits, flags stuff violations and
// counts destuffed bits. Define CAN_RX_DESTUFF_CRC_EN to add the running CRC-15.
module can_rx_destuff
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN,
   parameter int BIT_CNT_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 din,
   input  logic                 din_valid,
   output logic                 dout,
   output logic                 dout_valid,
   output logic                 stuff_err,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic [CAN_CRC_W-1:0] crc_out,
   output logic                 crc_zero
);

   localparam int                   RUN_W   = $clog2(STUFF_LEN + 1);
   localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(STUFF_LEN);
   localparam logic [BIT_CNT_W-1:0] CNT_MAX = '1;

   destuff_state_e         state, state_nxt;
   logic [RUN_W-1:0]       run_cnt, run_cnt_nxt;
   logic                   last_bit, last_bit_nxt;
   logic                   dout_nxt, dout_valid_nxt, stuff_err_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
   logic                   take;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         run_cnt    <= '0;
         last_bit   <= 1'b0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         stuff_err  <= 1'b0;
         bit_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         run_cnt    <= run_cnt_nxt;
         last_bit   <= last_bit_nxt;
         dout       <= dout_nxt;
         dout_valid <= dout_valid_nxt;
         stuff_err  <= stuff_err_nxt;
         bit_cnt    <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      run_cnt_nxt    = run_cnt;
      last_bit_nxt   = last_bit;
      dout_nxt       = dout;
      dout_valid_nxt = 1'b0;
      stuff_err_nxt  = stuff_err;
      bit_cnt_nxt    = bit_cnt;
      take           = 1'b0;

      case (state)
         ST_IDLE: begin
            run_cnt_nxt   = '0;
            last_bit_nxt  = 1'b0;
            stuff_err_nxt = 1'b0;
            bit_cnt_nxt   = '0;
            if (en) begin
               state_nxt = ST_RUN;
               // A strobe arriving with the rising enable is the SOF bit.
               take      = din_valid;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_nxt     = ST_IDLE;
               run_cnt_nxt   = '0;
               last_bit_nxt  = 1'b0;
               stuff_err_nxt = 1'b0;
               bit_cnt_nxt   = '0;
            end else begin
               take = din_valid;
            end
         end
         ST_ERROR: begin
            if (!en) begin
               state_nxt     = ST_IDLE;
               run_cnt_nxt   = '0;
               last_bit_nxt  = 1'b0;
               stuff_err_nxt = 1'b0;
               bit_cnt_nxt   = '0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (take) begin
         if (run_cnt == RUN_MAX) begin
            // Stuff bit: must differ from the run it terminates, and opens a new run.
            if (din != last_bit) begin
               last_bit_nxt = din;
               run_cnt_nxt  = RUN_W'(1);
            end else begin
               state_nxt     = ST_ERROR;
               stuff_err_nxt = 1'b1;
            end
         end else begin
            run_cnt_nxt    = (din == last_bit && run_cnt != '0) ? run_cnt + 1'b1 : RUN_W'(1);
            last_bit_nxt   = din;
            dout_nxt       = din;
            dout_valid_nxt = 1'b1;
            bit_cnt_nxt    = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
         end
      end
   end

`ifdef CAN_RX_DESTUFF_CRC_EN
   logic [CAN_CRC_W-1:0] crc;

   // Advances on the same edge that raises dout_valid; any cycle without en clears it.
   can_crc15 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!en),
      .en    (dout_valid_nxt),
      .din   (din),
      .crc   (crc)
   );

   assign crc_out  = crc;
   assign crc_zero = (crc == '0);
`else
   assign crc_out  = '0;
   assign crc_zero = 1'b0;
`endif

endmodule

// File: tb/tb_can_rx_destuff.sv
// Bench for can_rx_destuff: stuffing tables, error/SOF/reset/saturation
// sequences and, with CAN_RX_DESTUFF_CRC_EN, a full-frame CRC check.
module tb_can_rx_destuff;
   import can_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        dout, dout_valid, stuff_err, crc_zero;
   logic [6:0]  bit_cnt;
   logic [14:0] crc_out;

   int tests = 0;
   int fails = 0;
   logic exp_q[$];

   typedef struct {
      logic b;
      logic emit;
      logic last;
      int   cnt;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   can_rx_destuff #(.STUFF_LEN(5), .BIT_CNT_W(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .stuff_err  (stuff_err),
      .bit_cnt    (bit_cnt),
      .crc_out    (crc_out),
      .crc_zero   (crc_zero)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Scoreboard: every strobe must match the oldest expected bit.
   always @(posedge clk) begin
      #1;
      if (dout_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_strobe", 32'(dout_valid), 32'd0);
         else                   chk("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
   end

   task automatic send_bit(input logic b, input logic emit);
      @(negedge clk);
      din       = b;
      din_valid = 1'b1;
      if (emit) exp_q.push_back(b);
      @(posedge clk);
      #2;
      din_valid = 1'b0;
      chk("latency", 32'(exp_q.size()), 32'd0);
   endtask

   // Drops en with a strobe in the same cycle; that strobe must be ignored.
   task automatic end_frame();
      @(negedge clk);
      en        = 1'b0;
      din       = ~din;
      din_valid = 1'b1;
      @(posedge clk);
      #2;
      din_valid = 1'b0;
      chk("end_bit_cnt", 32'(bit_cnt), 32'd0);
      chk("end_stuff_err", 32'(stuff_err), 32'd0);
   endtask

   task automatic add(input logic b, input logic emit, input logic last, input int cnt);
      vec_t v;
      v.b = b; v.emit = emit; v.last = last; v.cnt = cnt;
      tbl.push_back(v);
   endtask

`ifdef CAN_RX_DESTUFF_CRC_EN
   logic frame_q[$];

   task automatic push_field(input logic [31:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) frame_q.push_back(v[i]);
   endtask

   function automatic logic [14:0] crc_calc(input logic bits[$]);
      logic [14:0] c = '0;
      logic        fb;
      foreach (bits[i]) begin
         fb = c[14] ^ bits[i];
         c  = {c[13:0], 1'b0};
         if (fb) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   task automatic send_stuffed(input logic bits[$]);
      int   run = 0;
      logic lb  = 1'b0;
      foreach (bits[i]) begin
         send_bit(bits[i], 1'b1);
         if (run > 0 && bits[i] == lb) run++;
         else run = 1;
         lb = bits[i];
         if (run == 5) begin
            send_bit(~lb, 1'b0);
            lb  = ~lb;
            run = 1;
         end
      end
   endtask
`endif

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_stuff_err", 32'(stuff_err), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      chk("rst_crc_out", 32'(crc_out), 32'd0);
`ifdef CAN_RX_DESTUFF_CRC_EN
      chk("rst_crc_zero", 32'(crc_zero), 32'd1);
`else
      chk("rst_crc_zero", 32'(crc_zero), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Strobe while en is low is ignored
      send_bit(1'b1, 1'b0);
      chk("idle_bit_cnt", 32'(bit_cnt), 32'd0);

      // Six identical bits -> stuff violation
      @(negedge clk);
      en = 1'b1;
      repeat (5) send_bit(1'b0, 1'b1);
      chk("pre_err_stuff_err", 32'(stuff_err), 32'd0);
      chk("pre_err_bit_cnt", 32'(bit_cnt), 32'd5);
      send_bit(1'b0, 1'b0);
      chk("err_stuff_err", 32'(stuff_err), 32'd1);
      chk("err_bit_cnt", 32'(bit_cnt), 32'd5);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      chk("err_held", 32'(stuff_err), 32'd1);
      end_frame();

      // Table: single stuff bit, then two stuff bits with run restart
      add(0,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0);
      add(1,0,0,0); add(1,1,0,0); add(0,1,1,7);
      add(1,1,0,0); add(1,1,0,0); add(1,1,0,0); add(1,1,0,0); add(1,1,0,0);
      add(0,0,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0); add(0,1,0,0);
      add(1,0,0,0); add(1,1,1,10);
      @(negedge clk);
      en = 1'b1;
      foreach (tbl[i]) begin
         send_bit(tbl[i].b, tbl[i].emit);
         if (tbl[i].last) begin
            chk("tbl_bit_cnt", 32'(bit_cnt), 32'(tbl[i].cnt));
            chk("tbl_stuff_err", 32'(stuff_err), 32'd0);
            end_frame();
            @(negedge clk);
            en = 1'b1;
         end
      end
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);

      // SOF strobe on the same cycle en rises (dout currently 1)
      en        = 1'b1;
      din       = 1'b0;
      din_valid = 1'b1;
      exp_q.push_back(1'b0);
      @(posedge clk);
      #2;
      din_valid = 1'b0;
      chk("sof_latency", 32'(exp_q.size()), 32'd0);
      chk("sof_bit_cnt", 32'(bit_cnt), 32'd1);
      chk("sof_dout", 32'(dout), 32'd0);

      // Reset mid-frame after 20 bits
      for (int i = 1; i < 20; i++) send_bit(i[0], 1'b1);
      chk("mid_bit_cnt", 32'(bit_cnt), 32'd20);
      @(negedge clk);
      rst_n     = 1'b0;
      din       = 1'b0;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
      chk("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
      chk("midrst_stuff_err", 32'(stuff_err), 32'd0);
      #1 din_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      send_bit(1'b0, 1'b1);
      chk("restart_bit_cnt", 32'(bit_cnt), 32'd1);
      end_frame();

      // Counter saturation
      @(negedge clk);
      en = 1'b1;
      for (int i = 0; i < 130; i++) send_bit(i[0], 1'b1);
      chk("sat_bit_cnt", 32'(bit_cnt), 32'd127);
      end_frame();

`ifdef CAN_RX_DESTUFF_CRC_EN
      begin
         logic        good[$];
         logic        bad[$];
         logic [14:0] c;
         frame_q.delete();
         push_field(32'd0, 1);
         push_field(32'h123, 11);
         push_field(32'd0, 3);
         push_field(32'd1, 4);
         push_field(32'hAA, 8);
         c = crc_calc(frame_q);
         push_field(32'(c), 15);
         good = frame_q;
         bad  = frame_q;
         bad[20] = ~bad[20];
         @(negedge clk);
         en = 1'b1;
         send_stuffed(good);
         chk("crc_good_zero", 32'(crc_zero), 32'd1);
         chk("crc_good_out", 32'(crc_out), 32'd0);
         chk("crc_good_err", 32'(stuff_err), 32'd0);
         end_frame();
         @(negedge clk);
         en = 1'b1;
         send_stuffed(bad);
         chk("crc_bad_zero", 32'(crc_zero), 32'd0);
         end_frame();
      end
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
